// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard controller: a 3-deep destination scoreboard stalls
// dependent instructions, redirects squash fetch/decode, and sys drains to halt.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  input  logic        dec_writes,
  input  logic [3:0]  dec_dst,
  input  logic [3:0]  dec_src,
  input  logic        dec_src_is_reg,
  input  logic        dec_reads_dst,
  input  logic        dec_is_sys,
  input  logic        wb_redirect,
  output logic        stall,
  output logic        squash,
  output logic        issue,
  output logic        halt,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  typedef struct packed {
    logic       vld;
    logic [3:0] dst;
  } sb_ent_t;

  // sb[0] = execute, sb[1] = writeback, sb[2] = retire
  sb_ent_t [2:0] sb_q, sb_d;
  state_t        state_q, state_d;
  logic [1:0]    sq_cnt_q, sq_cnt_d;
  logic [1:0]    drn_cnt_q, drn_cnt_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;
  logic [2:0]    hit;
  logic          hazard, run, redirect;

  always_comb begin
    hit = '0;
    for (int k = 0; k < 3; k++) begin
      hit[k] = sb_q[k].vld &
               ((dec_src_is_reg & (sb_q[k].dst == dec_src)) |
                (dec_reads_dst  & (sb_q[k].dst == dec_dst)));
    end
  end

  assign hazard   = dec_valid & (|hit);
  assign run      = (state_q == RUN);
  // A halted core ignores redirects entirely.
  assign redirect = wb_redirect & (state_q != HALTED);

  assign squash    = (sq_cnt_q != 2'd0);
  assign halt      = (state_q == HALTED);
  // Gated by reset so decode inputs cannot leak through while reset is held.
  assign stall     = ~reset & ((run & hazard & ~squash) | halt);
  assign issue     = ~reset & run & dec_valid & ~stall & ~squash;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    sb_d[2]     = sb_q[1];
    sb_d[1]     = sb_q[0];
    sb_d[0].vld = issue & dec_writes;
    sb_d[0].dst = dec_dst;
    // The execute-stage instruction is younger than the redirect: kill it.
    if (redirect) begin
      sb_d[1].vld = 1'b0;
      sb_d[0].vld = 1'b0;
    end

    if (redirect)    sq_cnt_d = 2'd2;
    else if (squash) sq_cnt_d = sq_cnt_q - 2'd1;
    else             sq_cnt_d = 2'd0;

    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    else                                    stall_cnt_d = stall_cnt_q;
  end

  always_comb begin
    state_d   = state_q;
    drn_cnt_d = drn_cnt_q;
    case (state_q)
      RUN: begin
        if (issue && dec_is_sys) begin
          state_d   = DRAIN;
          drn_cnt_d = 2'd3;
        end
      end
      DRAIN: begin
        if (wb_redirect) begin
          state_d   = RUN;
          drn_cnt_d = 2'd0;
        end else begin
          drn_cnt_d = drn_cnt_q - 2'd1;
          if (drn_cnt_q <= 2'd1) begin
            state_d   = HALTED;
            drn_cnt_d = 2'd0;
          end
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_q        <= '0;
      state_q     <= RUN;
      sq_cnt_q    <= 2'd0;
      drn_cnt_q   <= 2'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      sb_q        <= sb_d;
      state_q     <= state_d;
      sq_cnt_q    <= sq_cnt_d;
      drn_cnt_q   <= drn_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dec_valid = 1'b0, dec_writes = 1'b0;
  logic [3:0]  dec_dst = '0, dec_src = '0;
  logic        dec_src_is_reg = 1'b0, dec_reads_dst = 1'b0, dec_is_sys = 1'b0;
  logic        wb_redirect = 1'b0;
  logic        stall, squash, issue, halt;
  logic [15:0] stall_cnt;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_writes(dec_writes),
    .dec_dst(dec_dst), .dec_src(dec_src),
    .dec_src_is_reg(dec_src_is_reg), .dec_reads_dst(dec_reads_dst),
    .dec_is_sys(dec_is_sys), .wb_redirect(wb_redirect),
    .stall(stall), .squash(squash), .issue(issue), .halt(halt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: in_flight[k] = destination written by the instruction issued k+1 cycles ago.
  bit       m_v[3];
  int       m_d[3];
  int       m_mode;      // 0 running, 1 draining after sys, 2 halted
  int       m_drain_left;
  int       m_squash_left;
  int       m_cnt;
  bit       e_stall, e_squash, e_issue, e_halt;
  logic     a_stall, a_squash, a_issue, a_halt;
  logic [15:0] a_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin m_v[k] = 0; m_d[k] = 0; end
    m_mode = 0; m_drain_left = 0; m_squash_left = 0; m_cnt = 0;
  endtask

  task automatic model_eval();
    bit dep = 0;
    for (int k = 0; k < 3; k++)
      if (m_v[k] && ((dec_src_is_reg && m_d[k] == int'(dec_src)) ||
                     (dec_reads_dst  && m_d[k] == int'(dec_dst))))
        dep = 1;
    e_squash = (m_squash_left > 0);
    e_halt   = (m_mode == 2);
    e_stall  = e_halt || (m_mode == 0 && dec_valid && dep && !e_squash);
    e_issue  = (m_mode == 0) && dec_valid && !e_stall && !e_squash;
  endtask

  task automatic model_step();
    bit kill = wb_redirect && (m_mode != 2);
    if (e_stall && m_cnt < 65535) m_cnt++;
    m_v[2] = m_v[1];           m_d[2] = m_d[1];
    m_v[1] = m_v[0] && !kill;  m_d[1] = m_d[0];
    m_v[0] = e_issue && dec_writes && !kill;
    m_d[0] = int'(dec_dst);
    if (kill) m_squash_left = 2;
    else if (m_squash_left > 0) m_squash_left--;
    if (m_mode == 0) begin
      if (e_issue && dec_is_sys) begin m_mode = 1; m_drain_left = 3; end
    end else if (m_mode == 1) begin
      if (wb_redirect) m_mode = 0;
      else begin
        m_drain_left--;
        if (m_drain_left == 0) m_mode = 2;
      end
    end
  endtask

  // Entered and left at a falling edge; outputs sampled 1 time unit after drive.
  task automatic cyc(input bit v, input bit w, input logic [3:0] d, input logic [3:0] s,
                     input bit sr, input bit rdst, input bit sys, input bit rd);
    dec_valid = v; dec_writes = w; dec_dst = d; dec_src = s;
    dec_src_is_reg = sr; dec_reads_dst = rdst; dec_is_sys = sys; wb_redirect = rd;
    #1;
    model_eval();
    a_stall = stall; a_squash = squash; a_issue = issue; a_halt = halt; a_cnt = stall_cnt;
    chk("stall",     a_stall,  e_stall);
    chk("squash",    a_squash, e_squash);
    chk("issue",     a_issue,  e_issue);
    chk("halt",      a_halt,   e_halt);
    chk("stall_cnt", a_cnt,    m_cnt);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic async_rst();
    dec_valid = 1; dec_src_is_reg = 1; wb_redirect = 0;
    #2 reset = 1;
    #1;
    chk("rst_stall",  stall, 0);
    chk("rst_squash", squash, 0);
    chk("rst_issue",  issue, 0);
    chk("rst_halt",   halt, 0);
    chk("rst_cnt",    stall_cnt, 0);
    model_reset();
    @(negedge clk);
    reset = 0; dec_valid = 0;
  endtask

  initial begin
    int halted_for;
    model_reset();
    #1;
    chk("por_stall", stall, 0);
    chk("por_issue", issue, 0);
    chk("por_cnt",   stall_cnt, 0);
    @(negedge clk);
    reset = 0;

    // RAW on r1: three stall cycles, then issue
    cyc(1, 1, 4'd1, 4'd0, 0, 0, 0, 0);
    chk("raw_writer_issue", a_issue, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 4'd2, 4'd1, 1, 0, 0, 0);
      chk("raw_stall", a_stall, 1);
    end
    cyc(1, 1, 4'd2, 4'd1, 1, 0, 0, 0);
    chk("raw_issue4", a_issue, 1);
    chk("raw_cnt3",   a_cnt, 3);

    // Immediate operand never hazards
    async_rst();
    cyc(1, 1, 4'd1, 4'd0, 0, 0, 0, 0);
    cyc(1, 1, 4'd2, 4'd1, 0, 0, 0, 0);
    chk("imm_nostall", a_stall, 0);
    chk("imm_issue",   a_issue, 1);

    // Redirect while a hazard is pending
    async_rst();
    cyc(1, 1, 4'd15, 4'd0, 0, 0, 0, 0);
    cyc(1, 1, 4'd2, 4'd15, 1, 0, 0, 1);
    chk("r15_stall", a_stall, 1);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 4'd2, 4'd15, 1, 0, 0, 0);
      chk("sq_squash",  a_squash, 1);
      chk("sq_nostall", a_stall, 0);
    end
    cyc(1, 1, 4'd2, 4'd15, 1, 0, 0, 0);
    chk("sq_after_issue", a_issue, 1);

    // sys drains for three cycles then halts; redirects are ignored; counter saturates
    async_rst();
    cyc(1, 0, 4'd0, 4'd0, 0, 0, 1, 0);
    chk("sys_issue", a_issue, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 4'd3, 4'd4, 1, 0, 0, 0);
      chk("drain_noissue", a_issue, 0);
      chk("drain_nohalt",  a_halt, 0);
    end
    cyc(1, 0, 4'd3, 4'd4, 1, 0, 0, 0);
    chk("halt_4th", a_halt, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 4'd3, 4'd4, 1, 0, 0, i[0]);
      chk("halt_sticky",    a_halt, 1);
      chk("halt_nosquash",  a_squash, 0);
    end
    for (int i = 0; i < 65540; i++) cyc(1, 0, 4'd3, 4'd4, 1, 0, 0, 0);
    chk("cnt_saturated", a_cnt, 16'hFFFF);
    async_rst();
    chk("cnt_cleared", stall_cnt, 0);

    // Redirect one cycle after sys cancels the drain
    cyc(1, 0, 4'd0, 4'd0, 0, 0, 1, 0);
    cyc(1, 0, 4'd5, 4'd6, 1, 0, 0, 1);
    chk("sysrd_noissue", a_issue, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 4'd5, 4'd6, 1, 0, 0, 0);
      chk("sysrd_squash", a_squash, 1);
      chk("sysrd_nohalt", a_halt, 0);
    end
    cyc(1, 0, 4'd5, 4'd6, 1, 0, 0, 0);
    chk("sysrd_run_issue", a_issue, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 4'd5, 4'd6, 1, 0, 0, 0);
      chk("sysrd_nohalt2", a_halt, 0);
    end

    // Randomized traffic
    halted_for = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] d, s;
      d = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      s = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, d, s,
          $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0);
      halted_for = a_halt ? halted_for + 1 : 0;
      if (halted_for > 6 || $urandom_range(0, 299) == 0) begin
        async_rst();
        halted_for = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port dec_valid  input  1  decode slot holds a real instruction (not NOP).
REQ-004 SHALL have port dec_writes  input  1  decode instruction writes a register (not sys/pre/str).
REQ-005 SHALL have port dec_dst  input  4  decode Dest field.
REQ-006 SHALL have port dec_src  input  4  decode Op2 field.
REQ-007 SHALL have port dec_src_is_reg  input  1  Op2 names a register (isImm=0).
REQ-008 SHALL have port dec_reads_dst  input  1  instruction reads Dest as an operand.
REQ-009 SHALL have port dec_is_sys  input  1  decode instruction is OPsys.
REQ-010 SHALL have port wb_redirect  input  1  writeback stage is writing r15 this cycle.
REQ-011 SHALL have port stall  output  1  hold fetch/decode; inject NOP into execute.
REQ-012 SHALL have port squash  output  1  replace fetch and decode outputs with NOP.
REQ-013 SHALL have port issue  output  1  decode instruction advances this cycle.
REQ-014 SHALL have port halt  output  1  processor halted; sticky.
REQ-015 SHALL have port stall_cnt  output  16  count of stall cycles, saturating.

Function
REQ-016 SHALL keep a 3-entry scoreboard (S1 execute, S2 writeback, S3 retire); each entry holds valid bit + 4-bit dst.
REQ-017 SHALL shift every cycle: S3<=S2, S2<=S1, S1<={issue&dec_writes, dec_dst}.
REQ-018 SHALL raise hazard (combinational) when dec_valid and a valid entry's dst equals dec_src with dec_src_is_reg=1, or equals dec_dst with dec_reads_dst=1.
REQ-019 SHALL drive stall = hazard & ~squash & (state==RUN); while stalled, the instruction is held and S1 loads invalid.
REQ-020 SHALL drive issue = dec_valid & ~stall & ~squash & (state==RUN).
REQ-021 SHALL, on wb_redirect, load a 2-bit squash counter with 2; squash = (counter!=0); counter decrements to 0.
REQ-022 SHALL, on wb_redirect, invalidate S1 and clear it on the next shift; S2/S3 continue draining normally.
REQ-023 SHALL give squash priority over hazard when both are asserted in the same cycle: stall=0, issue=0.
REQ-024 SHALL, on a wb_redirect while the squash counter is non-zero, reload the counter to 2.
REQ-025 SHALL implement the FSM RUN -> DRAIN on (issue & dec_is_sys), loading a 2-bit drain counter with 3.
REQ-026 SHALL, in DRAIN, block issue and decrement the drain counter; at 0 the FSM moves to HALTED.
REQ-027 SHALL return from DRAIN to RUN when wb_redirect is asserted in DRAIN, because the sys instruction is younger than the redirect and is killed.
REQ-028 SHALL, in HALTED, assert halt=1 and hold stall=1 and issue=0 until reset; wb_redirect is ignored.
REQ-029 SHALL increment stall_cnt on every cycle with stall=1, saturating at 16'hFFFF with no wrap.
REQ-030 SHALL treat r15 as an ordinary scoreboard register; a hazard against r15 stalls.

Reset
REQ-031 SHALL, while reset=1, force stall=0, squash=0, issue=0, halt=0, stall_cnt=0, all entries invalid, both counters 0, FSM=RUN.
REQ-032 SHALL abort reset mid-operation immediately: DRAIN or HALTED returns to RUN and a pending squash is cancelled.
REQ-033 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification
REQ-034 SHALL pass: issue "add r1" (writes), then next cycle "add r2,r1" -> stall=1 for 3 cycles, issue on 4th cycle, stall_cnt=3.
REQ-035 SHALL pass: writer r1, then reader with dec_src_is_reg=0 and src=1 -> no stall, issue=1.
REQ-036 SHALL pass: wb_redirect pulse while hazard pending -> squash=1 for 2 cycles, stall=0 during squash, S1 invalid.
REQ-037 SHALL pass: issue sys -> issue=0 for 3 cycles, halt=1 on 4th cycle; halt stays 1 for 10 more cycles.
REQ-038 SHALL pass: issue sys, then wb_redirect 1 cycle later -> FSM back to RUN, halt stays 0, squash=1 for 2 cycles.
REQ-039 SHALL pass: preload stall_cnt near 16'hFFFF via a long stall, assert reset mid-stall -> all outputs 0 asynchronously, stall_cnt=0.
